// File: rtl/wrr_pkg.sv
// Shared sizes, reset weight and update-FSM state type for the WRR priority table.
package wrr_pkg;
    localparam int unsigned NUM_REQ = 32;
    localparam int unsigned ID_W    = 5;
    localparam int unsigned PRIO_W  = 4;
    localparam logic [PRIO_W-1:0] PRIO_RST = 4'd1;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        HOLD
    } upd_state_e;
endpackage

// File: rtl/wrr_prio_table_if.sv
// Update handshake, grant feedback and credit status bundle between arbiter and table.
interface wrr_prio_table_if;
    logic                        prio_upt;
    logic [wrr_pkg::ID_W-1:0]    prio_id;
    logic [wrr_pkg::PRIO_W-1:0]  prio;
    logic                        ack;
    logic                        gnt_vld;
    logic [wrr_pkg::ID_W-1:0]    gnt_id;
    logic [wrr_pkg::NUM_REQ-1:0] credit_avail;
    logic                        round_done;
    logic                        gnt_err;

    modport master (
        output prio_upt, prio_id, prio, gnt_vld, gnt_id,
        input  ack, credit_avail, round_done, gnt_err
    );

    modport slave (
        input  prio_upt, prio_id, prio, gnt_vld, gnt_id,
        output ack, credit_avail, round_done, gnt_err
    );
endinterface

// File: rtl/wrr_credit_cnt.sv
// One requester's credit counter: load beats reload beats a saturating decrement.
module wrr_credit_cnt
    import wrr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [PRIO_W-1:0] load_val,
    input  logic              reload,
    input  logic [PRIO_W-1:0] reload_val,
    input  logic              dec,
    output logic [PRIO_W-1:0] credit,
    output logic              zero
);
    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= PRIO_RST;
        end else if (load) begin
            credit <= load_val;
        end else if (reload) begin
            credit <= reload_val;
        end else if (dec && (credit != '0)) begin
            credit <= credit - PRIO_W'(1);
        end
    end

    assign zero = (credit == '0);
endmodule

// File: rtl/wrr_prio_table.sv
// Weighted round-robin weight/credit table with a 3-state update handshake and round reload.
module wrr_prio_table
    import wrr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    wrr_prio_table_if.slave  bus
);
    upd_state_e        state;
    upd_state_e        state_nxt;
    logic              ack_c;
    logic              upd_wr;
    logic [PRIO_W-1:0] prio_tbl [NUM_REQ];
    logic [PRIO_W-1:0] credit   [NUM_REQ];
    logic [NUM_REQ-1:0] zero;
    logic              tbl_any;
    logic              reload;
    logic              round_done_q;
    logic              gnt_err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.prio_upt) state_nxt = ACK;
            ACK:     state_nxt = HOLD;
            HOLD:    if (!bus.prio_upt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack_c  = (state == ACK);
        upd_wr = (state == IDLE) && bus.prio_upt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) prio_tbl[i] <= PRIO_RST;
        end else if (upd_wr) begin
            prio_tbl[bus.prio_id] <= bus.prio;
        end
    end

    always_comb begin
        tbl_any = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) tbl_any |= (prio_tbl[i] != '0);
    end

    assign reload = (zero == '1) && tbl_any;

    // Grants are masked during reload; an update to the same index still overrides inside the counter.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        wrr_credit_cnt u_cnt (
            .clk        (clk),
            .rst        (rst),
            .load       (upd_wr && (bus.prio_id == ID_W'(g))),
            .load_val   (bus.prio),
            .reload     (reload),
            .reload_val (prio_tbl[g]),
            .dec        (bus.gnt_vld && (bus.gnt_id == ID_W'(g)) && !reload),
            .credit     (credit[g]),
            .zero       (zero[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round_done_q <= 1'b0;
            gnt_err_q    <= 1'b0;
        end else begin
            round_done_q <= reload;
            if (bus.gnt_vld && (credit[bus.gnt_id] == '0)) gnt_err_q <= 1'b1;
        end
    end

    assign bus.ack          = ack_c;
    assign bus.credit_avail = ~zero;
    assign bus.round_done   = round_done_q;
    assign bus.gnt_err      = gnt_err_q;
endmodule

// File: tb/tb_wrr_prio_table.sv
// Directed scenarios for wrr_prio_table; expected values are worked out by hand.
module tb_wrr_prio_table;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    wrr_prio_table_if bus ();

    wrr_prio_table dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.prio_upt = 1'b0;
        bus.prio_id  = '0;
        bus.prio     = '0;
        bus.gnt_vld  = 1'b0;
        bus.gnt_id   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic grant(input int id);
        bus.gnt_vld = 1'b1;
        bus.gnt_id  = 5'(id);
        tick();
        bus.gnt_vld = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.credit_avail !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_avail got=%h exp=%h", bus.credit_avail, 32'hFFFF_FFFF); end
        checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", bus.ack); end
        checks++; if (bus.round_done !== 1'b0) begin failures++; $display("FAIL rst_round_done got=%b exp=0", bus.round_done); end
        checks++; if (bus.gnt_err !== 1'b0) begin failures++; $display("FAIL rst_gnt_err got=%b exp=0", bus.gnt_err); end
        tick();
        tick();
        checks++; if (bus.credit_avail !== 32'hFFFF_FFFF) begin failures++; $display("FAIL idle_avail got=%h exp=%h", bus.credit_avail, 32'hFFFF_FFFF); end
        checks++; if (bus.round_done !== 1'b0) begin failures++; $display("FAIL idle_round_done got=%b exp=0", bus.round_done); end
    endtask

    task automatic test_update();
        do_reset();
        bus.prio_upt = 1'b1; bus.prio_id = 5'd5; bus.prio = 4'd3;
        tick();
        checks++; if (bus.ack !== 1'b1) begin failures++; $display("FAIL upd_ack_high got=%b exp=1", bus.ack); end
        bus.prio_upt = 1'b0;
        tick();
        checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL upd_ack_one_cycle got=%b exp=0", bus.ack); end
        tick();
        checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL upd_hold_ack got=%b exp=0", bus.ack); end
        // earliest re-acceptance: three edges after the first accept
        bus.prio_upt = 1'b1; bus.prio_id = 5'd9; bus.prio = 4'd2;
        tick();
        checks++; if (bus.ack !== 1'b1) begin failures++; $display("FAIL upd_spacing_ack got=%b exp=1", bus.ack); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL upd_held_ignored cyc=%0d got=%b exp=0", i, bus.ack); end
        end
        bus.prio_upt = 1'b0;
        tick();
        grant(5);
        grant(5);
        checks++; if (bus.credit_avail[5] !== 1'b1) begin failures++; $display("FAIL upd_credit5_after2 got=%b exp=1", bus.credit_avail[5]); end
        grant(5);
        checks++; if (bus.credit_avail[5] !== 1'b0) begin failures++; $display("FAIL upd_credit5_after3 got=%b exp=0", bus.credit_avail[5]); end
        grant(9);
        checks++; if (bus.credit_avail[9] !== 1'b1) begin failures++; $display("FAIL upd_credit9_after1 got=%b exp=1", bus.credit_avail[9]); end
        grant(9);
        checks++; if (bus.credit_avail[9] !== 1'b0) begin failures++; $display("FAIL upd_credit9_after2 got=%b exp=0", bus.credit_avail[9]); end
        checks++; if (bus.gnt_err !== 1'b0) begin failures++; $display("FAIL upd_gnt_err got=%b exp=0", bus.gnt_err); end
    endtask

    task automatic test_round();
        do_reset();
        grant(0);
        checks++; if (bus.credit_avail !== 32'hFFFF_FFFE) begin failures++; $display("FAIL round_first got=%h exp=%h", bus.credit_avail, 32'hFFFF_FFFE); end
        for (int i = 1; i < 32; i++) grant(i);
        checks++; if (bus.credit_avail !== 32'h0) begin failures++; $display("FAIL round_drained got=%h exp=0", bus.credit_avail); end
        checks++; if (bus.round_done !== 1'b0) begin failures++; $display("FAIL round_done_early got=%b exp=0", bus.round_done); end
        tick();
        checks++; if (bus.credit_avail !== 32'hFFFF_FFFF) begin failures++; $display("FAIL round_reload got=%h exp=%h", bus.credit_avail, 32'hFFFF_FFFF); end
        checks++; if (bus.round_done !== 1'b1) begin failures++; $display("FAIL round_done_pulse got=%b exp=1", bus.round_done); end
        tick();
        checks++; if (bus.round_done !== 1'b0) begin failures++; $display("FAIL round_done_once got=%b exp=0", bus.round_done); end
        checks++; if (bus.gnt_err !== 1'b0) begin failures++; $display("FAIL round_gnt_err got=%b exp=0", bus.gnt_err); end
        // grant to a drained requester in the reload cycle still flags an error
        for (int i = 0; i < 32; i++) grant(i);
        grant(3);
        checks++; if (bus.credit_avail !== 32'hFFFF_FFFF) begin failures++; $display("FAIL round_reload_gnt got=%h exp=%h", bus.credit_avail, 32'hFFFF_FFFF); end
        checks++; if (bus.gnt_err !== 1'b1) begin failures++; $display("FAIL round_reload_err got=%b exp=1", bus.gnt_err); end
    endtask

    task automatic test_disable();
        do_reset();
        bus.prio_upt = 1'b1; bus.prio_id = 5'd7; bus.prio = 4'd0;
        tick();
        checks++; if (bus.ack !== 1'b1) begin failures++; $display("FAIL dis_ack got=%b exp=1", bus.ack); end
        checks++; if (bus.credit_avail !== 32'hFFFF_FF7F) begin failures++; $display("FAIL dis_avail got=%h exp=%h", bus.credit_avail, 32'hFFFF_FF7F); end
        bus.prio_upt = 1'b0;
        tick();
        tick();
        checks++; if (bus.gnt_err !== 1'b0) begin failures++; $display("FAIL dis_err_before got=%b exp=0", bus.gnt_err); end
        grant(7);
        checks++; if (bus.gnt_err !== 1'b1) begin failures++; $display("FAIL dis_err_set got=%b exp=1", bus.gnt_err); end
        checks++; if (bus.credit_avail[7] !== 1'b0) begin failures++; $display("FAIL dis_saturate got=%b exp=0", bus.credit_avail[7]); end
        tick();
        tick();
        checks++; if (bus.gnt_err !== 1'b1) begin failures++; $display("FAIL dis_err_sticky got=%b exp=1", bus.gnt_err); end
        do_reset();
        checks++; if (bus.gnt_err !== 1'b0) begin failures++; $display("FAIL dis_err_cleared got=%b exp=0", bus.gnt_err); end
    endtask

    task automatic test_all_disabled();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            bus.prio_upt = 1'b1; bus.prio_id = 5'(i); bus.prio = 4'd0;
            tick();
            bus.prio_upt = 1'b0;
            tick();
            tick();
        end
        checks++; if (bus.credit_avail !== 32'h0) begin failures++; $display("FAIL alldis_avail got=%h exp=0", bus.credit_avail); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.round_done !== 1'b0) begin failures++; $display("FAIL alldis_no_round cyc=%0d got=%b exp=0", i, bus.round_done); end
        end
        checks++; if (bus.credit_avail !== 32'h0) begin failures++; $display("FAIL alldis_no_reload got=%h exp=0", bus.credit_avail); end
    endtask

    task automatic test_collision();
        do_reset();
        bus.prio_upt = 1'b1; bus.prio_id = 5'd2; bus.prio = 4'd9;
        bus.gnt_vld  = 1'b1; bus.gnt_id  = 5'd2;
        tick();
        bus.gnt_vld = 1'b0;
        bus.prio_upt = 1'b0;
        for (int i = 0; i < 8; i++) grant(2);
        checks++; if (bus.credit_avail[2] !== 1'b1) begin failures++; $display("FAIL coll_after8 got=%b exp=1", bus.credit_avail[2]); end
        grant(2);
        checks++; if (bus.credit_avail[2] !== 1'b0) begin failures++; $display("FAIL coll_after9 got=%b exp=0", bus.credit_avail[2]); end
        checks++; if (bus.gnt_err !== 1'b0) begin failures++; $display("FAIL coll_gnt_err got=%b exp=0", bus.gnt_err); end
    endtask

    task automatic test_update_reload();
        do_reset();
        for (int i = 0; i < 32; i++) grant(i);
        bus.prio_upt = 1'b1; bus.prio_id = 5'd10; bus.prio = 4'd4;
        tick();
        bus.prio_upt = 1'b0;
        checks++; if (bus.credit_avail !== 32'hFFFF_FFFF) begin failures++; $display("FAIL updrl_avail got=%h exp=%h", bus.credit_avail, 32'hFFFF_FFFF); end
        checks++; if (bus.round_done !== 1'b1) begin failures++; $display("FAIL updrl_round got=%b exp=1", bus.round_done); end
        checks++; if (bus.ack !== 1'b1) begin failures++; $display("FAIL updrl_ack got=%b exp=1", bus.ack); end
        for (int i = 0; i < 3; i++) grant(10);
        checks++; if (bus.credit_avail[10] !== 1'b1) begin failures++; $display("FAIL updrl_after3 got=%b exp=1", bus.credit_avail[10]); end
        grant(10);
        checks++; if (bus.credit_avail[10] !== 1'b0) begin failures++; $display("FAIL updrl_after4 got=%b exp=0", bus.credit_avail[10]); end
        checks++; if (bus.credit_avail[11] !== 1'b1) begin failures++; $display("FAIL updrl_other got=%b exp=1", bus.credit_avail[11]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.prio_upt = 1'b1; bus.prio_id = 5'd8; bus.prio = 4'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.prio_upt = 1'b0;
        checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL rstedge_ack got=%b exp=0", bus.ack); end
        checks++; if (bus.credit_avail[8] !== 1'b1) begin failures++; $display("FAIL rstedge_discard got=%b exp=1", bus.credit_avail[8]); end
        tick();
        bus.prio_upt = 1'b1; bus.prio_id = 5'd5; bus.prio = 4'd3;
        tick();
        checks++; if (bus.ack !== 1'b1) begin failures++; $display("FAIL rstmid_pre_ack got=%b exp=1", bus.ack); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.prio_upt = 1'b0;
        checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL rstmid_ack got=%b exp=0", bus.ack); end
        // FSM must be back in IDLE: a fresh update is taken on the next edge
        bus.prio_upt = 1'b1; bus.prio_id = 5'd6; bus.prio = 4'd0;
        tick();
        bus.prio_upt = 1'b0;
        checks++; if (bus.ack !== 1'b1) begin failures++; $display("FAIL rstmid_idle_ack got=%b exp=1", bus.ack); end
        checks++; if (bus.credit_avail !== 32'hFFFF_FFBF) begin failures++; $display("FAIL rstmid_idle_avail got=%h exp=%h", bus.credit_avail, 32'hFFFF_FFBF); end
        for (int i = 0; i < 32; i++) if (i != 6) grant(i);
        tick();
        checks++; if (bus.credit_avail !== 32'hFFFF_FFBF) begin failures++; $display("FAIL rstmid_reload got=%h exp=%h", bus.credit_avail, 32'hFFFF_FFBF); end
        grant(5);
        checks++; if (bus.credit_avail[5] !== 1'b0) begin failures++; $display("FAIL rstmid_tbl5 got=%b exp=0", bus.credit_avail[5]); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_update();
        test_round();
        test_disable();
        test_all_disabled();
        test_collision();
        test_update_reload();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
